// File: rtl/rtx_scheduler_if.sv
// rtx_scheduler_if: frame control, per-core job/result and downstream pixel signals of the ray-tracer scheduler.
interface rtx_scheduler_if #(parameter int NUM_CORES = 2);
  logic                     start;
  logic                     busy;
  logic                     frame_done;
  logic [NUM_CORES-1:0]     core_new_ray;
  logic [10:0]              job_h;
  logic [9:0]               job_v;
  logic [NUM_CORES-1:0]     core_done;
  logic [16*NUM_CORES-1:0]  core_pixel;
  logic [11*NUM_CORES-1:0]  core_h;
  logic [10*NUM_CORES-1:0]  core_v;
  logic [NUM_CORES-1:0]     core_ack;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [15:0]              pix_data;
  logic [10:0]              pix_h;
  logic [9:0]               pix_v;
  modport master (
    input  start, core_done, core_pixel, core_h, core_v, pix_ready,
    output busy, frame_done, core_new_ray, job_h, job_v, core_ack, pix_valid, pix_data, pix_h, pix_v
  );
  modport slave (
    output start, core_done, core_pixel, core_h, core_v, pix_ready,
    input  busy, frame_done, core_new_ray, job_h, job_v, core_ack, pix_valid, pix_data, pix_h, pix_v
  );
endinterface

// File: rtl/rtx_scheduler.sv
// rtx_scheduler: raster job dispatch to NUM_CORES ray-tracer cores and round-robin result collection into one pixel stream.
// RTX_SCHEDULER_PERF_EN adds the frame_cycles output (cycles from leaving IDLE to frame_done inclusive).
module rtx_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 2
) (
  input  logic            clk,
  input  logic            rst,
  rtx_scheduler_if.master bus
`ifdef RTX_SCHEDULER_PERF_EN
  ,
  output logic [31:0]     frame_cycles
`endif
);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [19:0] TOTAL = 20'(WIDTH * HEIGHT);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_CORES-1:0] cbusy_q, cbusy_d, elig, ray, ack;
  logic [PW-1:0] dptr_q, dptr_d, cptr_q, cptr_d, dsel, csel;
  logic [10:0] h_q, h_d, oh_q, oh_d;
  logic [9:0] v_q, v_d, ov_q, ov_d;
  logic [15:0] od_q, od_d;
  logic val_q, val_d;
  logic [19:0] cnt_q, cnt_d;
  logic active, issue, load, fire, last_h;
  // first set bit of m at or after p, wrapping; lowest offset wins
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_CORES-1:0] m, input logic [PW-1:0] p);
    rr_pick = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (m[(int'(p) + k) % NUM_CORES]) rr_pick = PW'((int'(p) + k) % NUM_CORES);
  endfunction
  always_comb begin
    active  = state_q == DISPATCH || state_q == DRAIN;
    elig    = bus.core_done & cbusy_q;
    dsel    = rr_pick(~cbusy_q, dptr_q);
    csel    = rr_pick(elig, cptr_q);
    issue   = state_q == DISPATCH && !(&cbusy_q);
    fire    = val_q && bus.pix_ready;
    load    = active && (!val_q || bus.pix_ready) && |elig;
    last_h  = h_q == 11'(WIDTH - 1);
    ray     = issue ? NUM_CORES'(1) << dsel : '0;
    ack     = load ? NUM_CORES'(1) << csel : '0;
    cbusy_d = (cbusy_q | ray) & ~ack;
    dptr_d  = issue ? PW'((int'(dsel) + 1) % NUM_CORES) : dptr_q;
    cptr_d  = load ? PW'((int'(csel) + 1) % NUM_CORES) : cptr_q;
    val_d   = load || (val_q && !bus.pix_ready);
    od_d    = load ? bus.core_pixel[int'(csel)*16 +: 16] : od_q;
    oh_d    = load ? bus.core_h[int'(csel)*11 +: 11] : oh_q;
    ov_d    = load ? bus.core_v[int'(csel)*10 +: 10] : ov_q;
    cnt_d   = cnt_q + 20'(fire);
    h_d     = issue ? (last_h ? '0 : h_q + 11'd1) : h_q;
    v_d     = issue && last_h ? v_q + 10'd1 : v_q;
    state_d = state_q;
    if (state_q == IDLE && bus.start) begin
      state_d = DISPATCH;
      h_d     = '0;
      v_d     = '0;
      cnt_d   = '0;
    end
    if (issue && last_h && v_q == 10'(HEIGHT - 1)) state_d = DRAIN;
    if (state_q == DRAIN && cnt_q == TOTAL) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
    bus.busy         = active;
    bus.frame_done   = state_q == DONE;
    bus.core_new_ray = ray;
    bus.core_ack     = ack;
    bus.job_h        = issue ? h_q : '0;
    bus.job_v        = issue ? v_q : '0;
    bus.pix_valid    = val_q;
    bus.pix_data     = od_q;
    bus.pix_h        = oh_q;
    bus.pix_v        = ov_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cbusy_q <= '0;
      dptr_q  <= '0;
      cptr_q  <= '0;
      h_q     <= '0;
      v_q     <= '0;
      val_q   <= 1'b0;
      od_q    <= '0;
      oh_q    <= '0;
      ov_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cbusy_q <= cbusy_d;
      dptr_q  <= dptr_d;
      cptr_q  <= cptr_d;
      h_q     <= h_d;
      v_q     <= v_d;
      val_q   <= val_d;
      od_q    <= od_d;
      oh_q    <= oh_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
`ifdef RTX_SCHEDULER_PERF_EN
  logic [31:0] run_q, run_d, fc_q, fc_d;
  always_comb begin
    run_d = active ? run_q + 32'd1 : '0;
    fc_d  = state_q == DONE ? run_q + 32'd1 : fc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run_q <= '0;
      fc_q  <= '0;
    end else begin
      run_q <= run_d;
      fc_q  <= fc_d;
    end
  assign frame_cycles = fc_q;
`endif
endmodule
